// File: rtl/dmem_if.sv
// Load/store handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output MemRead, MemWrite, Adr, WData,
    input  RData, ready, stall, err
  );

  modport slave (
    input  MemRead, MemWrite, Adr, WData,
    output RData, ready, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: fixed wait states,
// one-cycle ready pulse on completion, and a stall to freeze the pipeline meanwhile.
//
// state | meaning
// IDLE  | waiting for a request; a valid one is latched and stall is raised
// WAIT  | counting down wait states on the latched request
// RESP  | access done on entry; ready=1, RData valid, inputs ignored
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   clr,
  dmem_if.slave  bus
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic              op_wr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  logic              req_any, req_valid, req_bad;
  logic [ADDR_W-1:0] adr_idx;
  logic              acc_en, acc_wr;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              unused_adr_hi;

  assign adr_idx       = bus.Adr[ADDR_W+1:2];
  assign unused_adr_hi = ^bus.Adr[31:ADDR_W+2];

  assign req_any   = bus.MemRead | bus.MemWrite;
  assign req_valid = (bus.MemRead ^ bus.MemWrite) && (bus.Adr[1:0] == 2'b00);
  assign req_bad   = req_any && !req_valid;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so it must
  // come straight from the bus rather than from the (not yet loaded) latch.
  always_comb begin
    acc_en    = (state_nxt == RESP) && !clr;
    acc_wr    = op_wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_wr    = bus.MemWrite;
      acc_idx   = adr_idx;
      acc_wdata = bus.WData;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= (state == IDLE) && req_bad;
      if (acc_en && !acc_wr) rdata_q <= mem[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      op_wr_q <= bus.MemWrite;
      idx_q   <= adr_idx;
      wdata_q <= bus.WData;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_wr) mem[acc_idx] <= acc_wdata;
  end

  assign bus.RData = rdata_q;
  assign bus.err   = err_q;
  assign bus.ready = (state == RESP);
  assign bus.stall = ((state == IDLE) && req_valid) || (state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states and
// one with none, compared against a word-array model and expected cycle counts.
module tb_dmem_responder;

  logic clk;
  logic clr;
  int   cyc;
  int   vectors;
  int   miscompares;

  dmem_if b2 ();
  dmem_if b0 ();

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_lat2 (.clk(clk), .clr(clr), .bus(b2.slave));
  dmem_responder #(.ADDR_W(8), .LATENCY(0)) u_lat0 (.clk(clk), .clr(clr), .bus(b0.slave));

  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  logic [31:0] last_rd2;
  logic [31:0] last_rd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [31:0] adr);
    return int'((adr >> 2) % 256);
  endfunction

  function automatic int exp_ready(input bit sel0);
    return sel0 ? 2 : 4;
  endfunction

  task automatic drive(input bit sel0, input bit rd, input bit wr,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (sel0) begin
      b0.MemRead = rd; b0.MemWrite = wr; b0.Adr = adr; b0.WData = wd;
    end else begin
      b2.MemRead = rd; b2.MemWrite = wr; b2.Adr = adr; b2.WData = wd;
    end
  endtask

  // Presents one request and holds it until ready; returns observed timing and data.
  task automatic access(input bit sel0, input bit rd, input bit wr,
                        input logic [31:0] adr, input logic [31:0] wd,
                        output int n_stall, output int rdy_cyc,
                        output logic [31:0] rdata, output int rdy_at);
    bit done;
    int c;
    n_stall = 0; rdy_cyc = 0; rdata = 32'd0; rdy_at = 0;
    done = 1'b0;
    c = 1;
    @(negedge clk);
    drive(sel0, rd, wr, adr, wd);
    while (!done && c <= 40) begin
      #1;
      if (sel0 ? b0.stall : b2.stall) n_stall++;
      if (sel0 ? b0.ready : b2.ready) begin
        rdy_cyc = c;
        rdata   = sel0 ? b0.RData : b2.RData;
        rdy_at  = cyc;
        done    = 1'b1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    drive(sel0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Runs one access and checks timing plus data against the model.
  task automatic checked_access(input string name, input bit sel0, input bit wr,
                                input logic [31:0] adr, input logic [31:0] wd);
    int n_stall, rdy_cyc, rdy_at, k;
    logic [31:0] rdata, expd;
    bit known;
    k = widx(adr);
    access(sel0, !wr, wr, adr, wd, n_stall, rdy_cyc, rdata, rdy_at);
    vectors++;
    if (rdy_cyc !== exp_ready(sel0)) begin
      miscompares++;
      $display("FAIL %s ready_cycle got %0d want %0d", name, rdy_cyc, exp_ready(sel0));
    end
    vectors++;
    if (n_stall !== exp_ready(sel0) - 1) begin
      miscompares++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, n_stall, exp_ready(sel0) - 1);
    end
    known = 1'b1;
    if (wr) begin
      expd = sel0 ? last_rd0 : last_rd2;
      if (sel0) m0[k] = wd; else m2[k] = wd;
    end else begin
      known = sel0 ? m0.exists(k) : m2.exists(k);
      expd  = known ? (sel0 ? m0[k] : m2[k]) : 32'd0;
      if (known) begin
        if (sel0) last_rd0 = expd; else last_rd2 = expd;
      end
    end
    if (known) begin
      vectors++;
      if (rdata !== expd) begin
        miscompares++;
        $display("FAIL %s rdata got %08h want %08h", name, rdata, expd);
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({b2.RData, b2.ready, b2.err} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_lat2 got rdata=%08h ready=%b err=%b want zeros", b2.RData, b2.ready, b2.err);
    end
    vectors++;
    if ({b0.RData, b0.ready, b0.err} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_lat0 got rdata=%08h ready=%b err=%b want zeros", b0.RData, b0.ready, b0.err);
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    vectors++;
    if ({b2.stall, b0.stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_stall got %b%b want 00", b2.stall, b0.stall);
    end
    last_rd2 = 32'd0;
    last_rd0 = 32'd0;
  endtask

  task automatic test_write_read();
    checked_access("wr_0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    checked_access("rd_0x10", 1'b0, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_wrap();
    checked_access("wr_0x400", 1'b0, 1'b1, 32'h0000_0400, 32'h0000_1234);
    checked_access("rd_wrap_0x0", 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reject();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
      else        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h77);
      #1;
      vectors++;
      if (b2.stall !== 1'b0) begin
        miscompares++;
        $display("FAIL reject%0d stall got %b want 0", i, b2.stall);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      vectors++;
      if ({b2.err, b2.ready, b2.stall} !== 3'b100) begin
        miscompares++;
        $display("FAIL reject%0d err/ready/stall got %b%b%b want 100", i, b2.err, b2.ready, b2.stall);
      end
      vectors++;
      if (b2.RData !== last_rd2) begin
        miscompares++;
        $display("FAIL reject%0d rdata got %08h want %08h", i, b2.RData, last_rd2);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (b2.err !== 1'b0) begin
        miscompares++;
        $display("FAIL reject%0d err_pulse got %b want 0", i, b2.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_stall, rdy_cyc, at1, at2;
    logic [31:0] rdata;
    access(1'b0, 1'b0, 1'b1, 32'h20, 32'hA5, n_stall, rdy_cyc, rdata, at1);
    m2[widx(32'h20)] = 32'hA5;
    access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, n_stall, rdy_cyc, rdata, at2);
    last_rd2 = 32'hA5;
    vectors++;
    if (at2 - at1 !== 4 || rdy_cyc !== 4) begin
      miscompares++;
      $display("FAIL b2b_gap got %0d want 4", at2 - at1);
    end
    vectors++;
    if (rdata !== 32'hA5) begin
      miscompares++;
      $display("FAIL b2b_rdata got %08h want 000000a5", rdata);
    end
  endtask

  task automatic test_reset_mid();
    checked_access("prior_0x30", 1'b0, 1'b1, 32'h30, 32'hCAFE0030);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h55);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    vectors++;
    if ({b2.RData, b2.ready, b2.err, b2.stall} !== 35'd0) begin
      miscompares++;
      $display("FAIL midreset_out got rdata=%08h ready=%b err=%b stall=%b want zeros",
               b2.RData, b2.ready, b2.err, b2.stall);
    end
    clr = 1'b0;
    last_rd2 = 32'd0;
    last_rd0 = 32'd0;
    checked_access("midreset_rd_0x30", 1'b0, 1'b0, 32'h30, 32'h0);
  endtask

  task automatic test_latency0();
    checked_access("lat0_wr_0x44", 1'b1, 1'b1, 32'h44, 32'h0BAD_F00D);
    checked_access("lat0_rd_0x44", 1'b1, 1'b0, 32'h44, 32'h0);
    checked_access("lat0_wr_0x48", 1'b1, 1'b1, 32'h48, 32'h1357_9BDF);
    checked_access("lat0_rd_0x48", 1'b1, 1'b0, 32'h48, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] adr;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 8; k++)
        checked_access("seed", s[0], 1'b1, 32'(k) << 2, $urandom);
    for (int i = 0; i < 60; i++) begin
      bit sel0, wr;
      sel0 = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      adr  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checked_access(wr ? "rand_wr" : "rand_rd", sel0, wr, adr, $urandom);
    end
  endtask

  initial begin
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_write_read();
    test_wrap();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_latency0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline; it is the memory-side end of the load/store interface.
- Accepts MemRead/MemWrite requests with address and write data from the EX/MEM register.
- Holds the request for a fixed number of wait states, performs the word access, and returns read data with a one-cycle ready pulse.
- Drives a stall to the hazard unit so the pipeline freezes while the access is outstanding.

Parameters:
- ADDR_W, 8: word-index width; memory holds 2**ADDR_W 32-bit words.
- LATENCY, 2: wait-state cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  reset: synchronous, active-high.
- MemRead  input  1  load request from MEM stage.
- MemWrite  input  1  store request from MEM stage.
- Adr  input  32  byte address (ALU result).
- WData  input  32  store data.
- RData  output  32  load data, registered.
- ready  output  1  one-cycle pulse: access complete.
- stall  output  1  combinational: freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- err  output  1  one-cycle pulse: misaligned or conflicting request rejected.

Behaviour:
- Reset (clr high at a clk edge): state=IDLE, wait counter=0, RData=0, ready=0, err=0. Memory array is not cleared. Reset mid-access aborts it; a pending write is not performed.
- Index = Adr[ADDR_W+1:2]. Adr[31:ADDR_W+2] is ignored, so addresses wrap modulo the memory size.
- A request is valid when exactly one of MemRead/MemWrite is high and Adr[1:0]==0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Valid request: latch op, index and WData. Then go to WAIT with counter=LATENCY-1, or to RESP directly if LATENCY==0.
  - Invalid request (both strobes high, or Adr[1:0]!=0): err=1 for the next cycle, stay IDLE, no access, no stall.
  - No request: stay IDLE.
- WAIT: counter decrements each cycle; go to RESP when it reaches 0.
- Access happens on the edge entering RESP:
  - Write: mem[index] <= latched WData.
  - Read: RData <= mem[index].
- RESP: ready=1 for exactly this cycle; RData is valid. Unconditionally return to IDLE; inputs in RESP are ignored because they still carry the completed request.
- stall = (IDLE and valid request) or WAIT. stall is low in RESP, so the pipeline advances at the end of RESP.
- Total access time is LATENCY+2 cycles, of which stall is high for LATENCY+1.
- Back-to-back accesses: a new request is accepted in the IDLE cycle immediately after RESP.
- RData holds its value until the next read completes; writes leave RData unchanged. ready stays 0 for rejected requests.
- Inputs must remain stable while stall=1. Only the latched copy is used after acceptance, so input changes in WAIT have no effect.
- A read of a location written by the immediately preceding store returns the new data.

Test Plan:
1. LATENCY=2: clr, then MemWrite with Adr=0x10, WData=0xDEADBEEF -> stall high for 3 cycles; ready pulses in cycle 4; then MemRead Adr=0x10 -> ready in 4 cycles with RData=0xDEADBEEF.
2. Wrap: with ADDR_W=8, write 0x1234 to Adr=0x0000_0400, then read Adr=0x0 -> RData=0x1234.
3. Misaligned: MemRead with Adr=0x13 -> err=1 the next cycle, stall=0, ready=0, RData unchanged. Both strobes high -> same response.
4. Back-to-back: store 0xA5 to 0x20, then load 0x20 immediately after ready -> second ready exactly 4 cycles after the first; RData=0xA5.
5. Reset mid-op: MemWrite 0x55 to 0x30; assert clr during WAIT -> outputs return to 0 next cycle; a later read of 0x30 returns the prior contents, not 0x55.
6. LATENCY=0: read -> stall high 1 cycle, ready in cycle 2; a write followed by a read of the same address returns the written value.
